wbregfile: RTL and testbench
============================

# wbregfile

Write-back stage and architectural register file of the semiMIPS pipeline. It consumes the write-back control bundle (memtoreg, regwr, fin) at the output of the WB pipeline register, selects the write-back value, and commits it to a 2**ADDRW-entry general-purpose register file. It serves the two decode-stage read ports with write-through bypass. It also latches the processor halt on `fin` and counts retired instructions.

## Interface
Parameters:
- DATAW, 32, data word width
- ADDRW, 5, register address width; the file has 2**ADDRW entries

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- memtoregin  input  2  write-back source select, from the WB pipeline register
- regwrin  input  1  register write enable, from the WB pipeline register
- finin  input  1  program-finish flag, from the WB pipeline register
- aluresult  input  DATAW  ALU result carried to WB
- memdata  input  DATAW  load data carried to WB
- pcplus4  input  DATAW  link address (PC+4) carried to WB
- wraddr  input  ADDRW  destination register number
- rdaddra  input  ADDRW  read port A address (rs)
- rdaddrb  input  ADDRW  read port B address (rt)
- rddataa  output  DATAW  read port A data
- rddatab  output  DATAW  read port B data
- wbdata  output  DATAW  selected write-back value
- halted  output  1  sticky halt flag
- retired  output  32  retired-instruction counter

## Operation
- Write-back mux (combinational) on `wbdata`:
  - memtoregin 00: aluresult
  - memtoregin 01: memdata
  - memtoregin 10: pcplus4
  - memtoregin 11: aluresult (reserved code, treated as 00)
- Commit enable: `we = regwrin & ~halted & (wraddr != 0)`. On a rising edge with `we` = 1, regs[wraddr] <= wbdata.
- Register 0 is hardwired to zero. Writes to it are dropped, and reads of address 0 return 0 on both ports regardless of bypass.
- Read ports are combinational:
  - If rdaddrX == wraddr and `we` = 1, rddataX = wbdata (write-through bypass, so a decode read in the same cycle sees the committing value).
  - Otherwise, rddataX = regs[rdaddrX].
- Halt state machine, two states:
  - RUN: halted = 0. If finin = 1 at an edge, go to HALT.
  - HALT: halted = 1. Stay in HALT until rst.
- The instruction carrying fin commits its own regwrin write in its cycle. Every write presented after that is suppressed.
- Retired counter: increments by 1 at each edge where `(regwrin | finin) & ~halted`.
  - Bubbles and flushed slots (all controls 0) do not count.
  - The counter is 32 bits and wraps from 0xFFFFFFFF to 0.
- Stores and branches (regwrin = 0, finin = 0) are not counted.

## Timing
- Reset (rst = 1 at an edge):
  - All registers clear to 0; halted = 0 (RUN); retired = 0.
  - rst takes priority over any simultaneous write, fin, or count in that cycle.
  - Reset in the middle of a run, including while in HALT, returns the block to this state at the next edge.
- Write latency: the register contents are updated at the edge ending the WB cycle. The bypass makes the value visible on the read ports during that same WB cycle.
- halted rises one cycle after finin is sampled high.
- retired reflects a retiring instruction one cycle after its WB cycle.
- A read of a register on one port and a write of the same register on the other port in the same cycle both resolve via the bypass. Both read ports may bypass at once.
- No stall input: every cycle is a WB cycle. The flush behaviour of the upstream register arrives here as zero controls.

## Test plan
- Reset, then read all 32 addresses -> every read returns 0; halted = 0; retired = 0.
- regwrin = 1, memtoregin = 00, aluresult = 0x1234, wraddr = 5, with rdaddra = 5 in the same cycle -> rddataa = 0x1234 in that cycle. Next cycle, regs[5] reads 0x1234 and retired = 1.
- Mux check, wraddr = 7:
  - memtoregin = 01, memdata = 0xDEADBEEF -> regs[7] = 0xDEADBEEF.
  - memtoregin = 10, pcplus4 = 0x40 -> regs[7] = 0x40.
  - memtoregin = 11, aluresult = 0x99 -> regs[7] = 0x99.
- Write 0xFFFF to wraddr = 0 with rdaddra = rdaddrb = 0 -> both ports read 0 in that cycle and afterwards; retired still increments.
- finin = 1 together with regwrin = 1, wraddr = 3, aluresult = 0xA -> regs[3] = 0xA and halted = 1 next cycle. A following write of 0xB to r3 is ignored and retired does not change. rst = 1 for one cycle -> halted = 0, r3 = 0.
- Preload retired to 0xFFFFFFFF by forced deposit or by a long run, then retire one instruction -> retired = 0.

Source files
------------

// File: rtl/wbregfile.sv
// semiMIPS write-back stage: source mux, register file with write-through read bypass,
// sticky halt on fin and a retired-instruction counter.
module wbregfile #(
  parameter int unsigned DATAW = 32,
  parameter int unsigned ADDRW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       memtoregin,
  input  logic             regwrin,
  input  logic             finin,
  input  logic [DATAW-1:0] aluresult,
  input  logic [DATAW-1:0] memdata,
  input  logic [DATAW-1:0] pcplus4,
  input  logic [ADDRW-1:0] wraddr,
  input  logic [ADDRW-1:0] rdaddra,
  input  logic [ADDRW-1:0] rdaddrb,
  output logic [DATAW-1:0] rddataa,
  output logic [DATAW-1:0] rddatab,
  output logic [DATAW-1:0] wbdata,
  output logic             halted,
  output logic [31:0]      retired
);

  localparam int unsigned NumRegs = 2 ** ADDRW;

  typedef enum logic {StRun, StHalt} state_e;

  state_e           state_q, state_d;
  logic [DATAW-1:0] regs_q [NumRegs];
  logic [DATAW-1:0] regs_d [NumRegs];
  logic [31:0]      retired_q, retired_d;
  logic             we;

  // Code 11 is reserved and behaves like 00.
  always_comb begin
    unique case (memtoregin)
      2'b01:   wbdata = memdata;
      2'b10:   wbdata = pcplus4;
      default: wbdata = aluresult;
    endcase
  end

  assign halted  = (state_q == StHalt);
  assign retired = retired_q;
  assign we      = regwrin & ~halted & (wraddr != '0);

  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[wraddr] = wbdata;
    end
    regs_d[0] = '0;
  end

  // r0 reads as zero even when a (dropped) write to it is in flight.
  always_comb begin
    if (rdaddra == '0) begin
      rddataa = '0;
    end else if (we && (rdaddra == wraddr)) begin
      rddataa = wbdata;
    end else begin
      rddataa = regs_q[rdaddra];
    end
  end

  always_comb begin
    if (rdaddrb == '0) begin
      rddatab = '0;
    end else if (we && (rdaddrb == wraddr)) begin
      rddatab = wbdata;
    end else begin
      rddatab = regs_q[rdaddrb];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (finin) state_d = StHalt;
      StHalt:  state_d = StHalt;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    retired_d = retired_q;
    if ((regwrin | finin) & ~halted) begin
      retired_d = retired_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      retired_q <= '0;
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      regs_q    <= regs_d;
    end
  end

endmodule

// File: tb/tb_wbregfile.sv
// Self-checking bench for wbregfile: directed vector table, counter wrap, random run vs model.
module tb_wbregfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  memtoregin;
  logic        regwrin, finin;
  logic [31:0] aluresult, memdata, pcplus4;
  logic [4:0]  wraddr, rdaddra, rdaddrb;
  logic [31:0] rddataa, rddatab, wbdata;
  logic        halted;
  logic [31:0] retired;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_regs [32];
  logic        m_halted;
  logic [31:0] m_retired;

  always #5 clk = ~clk;

  wbregfile #(.DATAW(32), .ADDRW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .memtoregin (memtoregin),
    .regwrin    (regwrin),
    .finin      (finin),
    .aluresult  (aluresult),
    .memdata    (memdata),
    .pcplus4    (pcplus4),
    .wraddr     (wraddr),
    .rdaddra    (rdaddra),
    .rdaddrb    (rdaddrb),
    .rddataa    (rddataa),
    .rddatab    (rddatab),
    .wbdata     (wbdata),
    .halted     (halted),
    .retired    (retired)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  mtr;
    logic        rw;
    logic        fin;
    logic [31:0] alu, mem, pc;
    logic [4:0]  wa, ra, rb;
    logic [31:0] ea, eb, ewb;
    logic        eh;
    logic [31:0] eret;
  } vec_t;

  function automatic vec_t mk(logic r, logic [1:0] mtr, logic rw, logic fin, logic [31:0] alu,
                              logic [31:0] mem, logic [31:0] pc, logic [4:0] wa, logic [4:0] ra,
                              logic [4:0] rb, logic [31:0] ea, logic [31:0] eb,
                              logic [31:0] ewb, logic eh, logic [31:0] eret);
    vec_t v;
    v.rst = r; v.mtr = mtr; v.rw = rw; v.fin = fin;
    v.alu = alu; v.mem = mem; v.pc = pc;
    v.wa = wa; v.ra = ra; v.rb = rb;
    v.ea = ea; v.eb = eb; v.ewb = ewb; v.eh = eh; v.eret = eret;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    rst = v.rst; memtoregin = v.mtr; regwrin = v.rw; finin = v.fin;
    aluresult = v.alu; memdata = v.mem; pcplus4 = v.pc;
    wraddr = v.wa; rdaddra = v.ra; rdaddrb = v.rb;
  endtask

  function automatic logic [31:0] m_wb();
    case (memtoregin)
      2'b01:   return memdata;
      2'b10:   return pcplus4;
      default: return aluresult;
    endcase
  endfunction

  function automatic logic m_we();
    return regwrin && !m_halted && wraddr != 0;
  endfunction

  function automatic logic [31:0] m_read(logic [4:0] a);
    if (a == 0) return 32'd0;
    if (m_we() && a == wraddr) return m_wb();
    return m_regs[a];
  endfunction

  // Advance one clock edge, updating the model from the inputs held across it.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = 32'd0;
      m_halted  = 1'b0;
      m_retired = 32'd0;
    end else begin
      if (m_we()) m_regs[wraddr] = m_wb();
      if ((regwrin || finin) && !m_halted) m_retired = m_retired + 32'd1;
      if (finin) m_halted = 1'b1;
    end
    #1;
  endtask

  task automatic check_model(string tag);
    check({tag, ".rddataa"}, rddataa, m_read(rdaddra));
    check({tag, ".rddatab"}, rddatab, m_read(rdaddrb));
    check({tag, ".wbdata"}, wbdata, m_wb());
    check({tag, ".halted"}, {31'd0, halted}, {31'd0, m_halted});
    check({tag, ".retired"}, retired, m_retired);
  endtask

  vec_t tbl [$];
  vec_t idle;

  initial begin
    foreach (m_regs[i]) m_regs[i] = 32'd0;
    m_halted  = 1'b0;
    m_retired = 32'd0;

    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl.push_back(mk(0, 0, 1, 0, 'h1234, 0, 0, 5, 5, 6, 'h1234, 0, 'h1234, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 5, 'h1234, 'h1234, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 'hDEADBEEF, 0, 7, 7, 5, 'hDEADBEEF, 'h1234, 'hDEADBEEF, 0, 1));
    tbl.push_back(mk(0, 2, 1, 0, 0, 0, 'h40, 7, 0, 7, 0, 'h40, 'h40, 0, 2));
    tbl.push_back(mk(0, 3, 1, 0, 'h99, 'h55, 'h66, 7, 7, 7, 'h99, 'h99, 'h99, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 5, 'h99, 'h1234, 0, 0, 4));
    tbl.push_back(mk(0, 0, 1, 0, 'hFFFF, 0, 0, 0, 0, 0, 0, 0, 'hFFFF, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5));
    tbl.push_back(mk(0, 0, 0, 0, 'h77, 0, 0, 5, 5, 5, 'h1234, 'h1234, 'h77, 0, 5));
    tbl.push_back(mk(0, 0, 1, 1, 'hA, 0, 0, 3, 3, 0, 'hA, 0, 'hA, 0, 5));
    tbl.push_back(mk(0, 0, 1, 0, 'hB, 0, 0, 3, 3, 3, 'hA, 'hA, 'hB, 1, 6));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 7, 'hA, 'h99, 0, 1, 6));
    tbl.push_back(mk(1, 0, 1, 0, 'hC, 0, 0, 3, 3, 3, 'hA, 'hA, 'hC, 1, 6));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 7, 0, 0, 0, 0, 0));

    // Reset, then every address reads zero.
    drive(idle);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset.halted", {31'd0, halted}, 32'd0);
    check("reset.retired", retired, 32'd0);
    for (int i = 0; i < 32; i++) begin
      rdaddra = 5'(i);
      rdaddrb = 5'(31 - i);
      #1;
      check($sformatf("reset.rda[%0d]", i), rddataa, 32'd0);
      check($sformatf("reset.rdb[%0d]", 31 - i), rddatab, 32'd0);
    end
    tick();

    // Directed vectors: expectations observed within the cycle, before its closing edge.
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      #2;
      check($sformatf("vec%0d.rddataa", i), rddataa, tbl[i].ea);
      check($sformatf("vec%0d.rddatab", i), rddatab, tbl[i].eb);
      check($sformatf("vec%0d.wbdata", i), wbdata, tbl[i].ewb);
      check($sformatf("vec%0d.halted", i), {31'd0, halted}, {31'd0, tbl[i].eh});
      check($sformatf("vec%0d.retired", i), retired, tbl[i].eret);
      tick();
    end

    // Counter wrap: deposit all-ones, retire one instruction.
    drive(idle);
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    m_retired = 32'hFFFF_FFFF;
    #1;
    check("wrap.preload", retired, 32'hFFFF_FFFF);
    regwrin = 1'b1; wraddr = 5'd1; aluresult = 32'h5;
    #1;
    tick();
    drive(idle);
    #1;
    check("wrap.retired", retired, 32'd0);
    tick();

    // Random run against the model, with occasional fin and reset.
    for (int c = 0; c < 600; c++) begin
      rst        = ($urandom_range(0, 59) == 0);
      memtoregin = 2'($urandom_range(0, 3));
      regwrin    = ($urandom_range(0, 3) != 0);
      finin      = ($urandom_range(0, 39) == 0);
      aluresult  = $urandom;
      memdata    = $urandom;
      pcplus4    = $urandom;
      wraddr     = 5'($urandom_range(0, 31));
      rdaddra    = ($urandom_range(0, 2) == 0) ? wraddr : 5'($urandom_range(0, 31));
      rdaddrb    = ($urandom_range(0, 2) == 0) ? wraddr : 5'($urandom_range(0, 31));
      #2;
      check_model($sformatf("rnd%0d", c));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
